// File: rtl/ps2_keyboard.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | ps2_keyboard : PS/2 set-2 receiver with Hack keycode translation          |
// | Revision 1.0                                                              |
// +---------------------------------------------------------------------------+
module ps2_keyboard #(
   parameter int FILTER_LEN     = 4,
   parameter int TIMEOUT_CYCLES = 25000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] keyboard,
   output logic [7:0] scan_code,
   output logic       scan_valid,
   output logic       frame_err
);

   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
   localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } state_t;

   logic          clk_s1, clk_s2, data_s1, data_s2;
   logic          clk_filt;
   logic [FW-1:0] filt_cnt;
   logic          fall;

   state_t        state;
   logic [7:0]    shift;
   logic [2:0]    bit_cnt;
   logic          par_bit;
   logic [TW-1:0] tmo_cnt;

   logic          ext, brk;
   logic [7:0]    hack;

   // Lines idle high, so the synchronisers and filter reset to 1 to avoid a false fall.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         clk_s1   <= 1'b1;
         clk_s2   <= 1'b1;
         data_s1  <= 1'b1;
         data_s2  <= 1'b1;
         clk_filt <= 1'b1;
         filt_cnt <= '0;
      end else begin
         clk_s1  <= ps2_clk;
         clk_s2  <= clk_s1;
         data_s1 <= ps2_data;
         data_s2 <= data_s1;
         if (clk_s2 == clk_filt) begin
            filt_cnt <= '0;
         end else if (filt_cnt == FILT_LAST) begin
            clk_filt <= clk_s2;
            filt_cnt <= '0;
         end else begin
            filt_cnt <= filt_cnt + 1'b1;
         end
      end
   end

   assign fall = clk_filt && !clk_s2 && (filt_cnt == FILT_LAST);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         shift      <= '0;
         bit_cnt    <= '0;
         par_bit    <= 1'b0;
         tmo_cnt    <= '0;
         scan_code  <= '0;
         scan_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         scan_valid <= 1'b0;
         frame_err  <= 1'b0;

         if (state == IDLE || fall) begin
            tmo_cnt <= '0;
         end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
         end

         if (state != IDLE && !fall && tmo_cnt == TMO_LAST) begin
            state     <= IDLE;
            frame_err <= 1'b1;
         end else if (fall) begin
            case (state)
               IDLE: begin
                  if (!data_s2) begin
                     state   <= DATA;
                     bit_cnt <= '0;
                  end
               end
               DATA: begin
                  shift   <= {data_s2, shift[7:1]};
                  bit_cnt <= bit_cnt + 1'b1;
                  if (bit_cnt == 3'd7) begin
                     state <= PARITY;
                  end
               end
               PARITY: begin
                  par_bit <= data_s2;
                  state   <= STOP;
               end
               STOP: begin
                  // Odd parity: data bits plus parity bit must XOR to 1.
                  if (data_s2 && (^{shift, par_bit})) begin
                     scan_code  <= shift;
                     scan_valid <= 1'b1;
                  end else begin
                     frame_err <= 1'b1;
                  end
                  state <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   always_comb begin
      hack = 8'd0;
      case ({ext, scan_code})
         9'h01C: hack = 8'd65;
         9'h032: hack = 8'd66;
         9'h021: hack = 8'd67;
         9'h023: hack = 8'd68;
         9'h024: hack = 8'd69;
         9'h02B: hack = 8'd70;
         9'h034: hack = 8'd71;
         9'h033: hack = 8'd72;
         9'h043: hack = 8'd73;
         9'h03B: hack = 8'd74;
         9'h042: hack = 8'd75;
         9'h04B: hack = 8'd76;
         9'h03A: hack = 8'd77;
         9'h031: hack = 8'd78;
         9'h044: hack = 8'd79;
         9'h04D: hack = 8'd80;
         9'h015: hack = 8'd81;
         9'h02D: hack = 8'd82;
         9'h01B: hack = 8'd83;
         9'h02C: hack = 8'd84;
         9'h03C: hack = 8'd85;
         9'h02A: hack = 8'd86;
         9'h01D: hack = 8'd87;
         9'h022: hack = 8'd88;
         9'h035: hack = 8'd89;
         9'h01A: hack = 8'd90;
         9'h045: hack = 8'd48;
         9'h016: hack = 8'd49;
         9'h01E: hack = 8'd50;
         9'h026: hack = 8'd51;
         9'h025: hack = 8'd52;
         9'h02E: hack = 8'd53;
         9'h036: hack = 8'd54;
         9'h03D: hack = 8'd55;
         9'h03E: hack = 8'd56;
         9'h046: hack = 8'd57;
         9'h029: hack = 8'd32;
         9'h05A: hack = 8'd128;
         9'h066: hack = 8'd129;
         9'h076: hack = 8'd140;
         9'h16B: hack = 8'd130;
         9'h175: hack = 8'd131;
         9'h174: hack = 8'd132;
         9'h172: hack = 8'd133;
         default: hack = 8'd0;
      endcase
   end

   // Decode runs one cycle behind scan_valid so keyboard lands at N+2.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         keyboard <= '0;
         ext      <= 1'b0;
         brk      <= 1'b0;
      end else if (frame_err) begin
         ext <= 1'b0;
         brk <= 1'b0;
      end else if (scan_valid) begin
         if (scan_code == 8'hE0) begin
            ext <= 1'b1;
         end else if (scan_code == 8'hF0) begin
            brk <= 1'b1;
         end else begin
            ext <= 1'b0;
            brk <= 1'b0;
            if (hack != 8'd0) begin
               if (!brk) begin
                  keyboard <= hack;
               end else if (hack == keyboard) begin
                  keyboard <= 8'd0;
               end
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ps2_keyboard.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_ps2_keyboard : directed bench for ps2_keyboard                         |
// | Revision 1.0                                                              |
// +---------------------------------------------------------------------------+
module tb_ps2_keyboard;

   localparam int TIMEOUT = 25000;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic [7:0] keyboard, scan_code;
   logic       scan_valid, frame_err;

   int checks = 0;
   int errors = 0;

   int       sv_pulses = 0, fe_pulses = 0, both_cnt = 0, sv_long = 0;
   logic     sv_prev = 1'b0, grab_next = 1'b0;
   logic [7:0] last_code = 8'h00, kbd_at_sv = 8'h00, kbd_after_sv = 8'h00;

   ps2_keyboard #(.FILTER_LEN(4), .TIMEOUT_CYCLES(TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
      .keyboard(keyboard), .scan_code(scan_code),
      .scan_valid(scan_valid), .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (scan_valid) begin
         sv_pulses = sv_pulses + 1;
         last_code = scan_code;
         kbd_at_sv = keyboard;
         grab_next = 1'b1;
      end else if (grab_next) begin
         kbd_after_sv = keyboard;
         grab_next = 1'b0;
      end
      if (frame_err) fe_pulses = fe_pulses + 1;
      if (scan_valid && frame_err) both_cnt = both_cnt + 1;
      if (scan_valid && sv_prev) sv_long = sv_long + 1;
      sv_prev = scan_valid;
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Sends the first nbits of a frame: start, 8 data LSB first, parity, stop.
   task automatic send_bits(input logic [7:0] b, input logic bad_par,
                            input logic bad_stop, input int nbits);
      logic [10:0] f;
      f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         @(negedge clk);
         ps2_data = f[i];
         wait_cyc(10);
         ps2_clk = 1'b0;
         wait_cyc(20);
         ps2_clk = 1'b1;
         wait_cyc(10);
      end
      ps2_data = 1'b1;
      wait_cyc(20);
   endtask

   task automatic send_byte(input logic [7:0] b);
      send_bits(b, 1'b0, 1'b0, 11);
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      wait_cyc(5);
      checks++; if (keyboard !== 8'd0) begin errors++; $display("FAIL reset_keyboard: got %0d expected 0", keyboard); end
      checks++; if (scan_code !== 8'd0) begin errors++; $display("FAIL reset_scan_code: got %h expected 00", scan_code); end
      checks++; if (scan_valid !== 1'b0) begin errors++; $display("FAIL reset_scan_valid: got %b expected 0", scan_valid); end
      checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
      rst_n = 1'b1;
      wait_cyc(5);
   endtask

   task automatic test_make;
      int sv0;
      sv0 = sv_pulses;
      send_byte(8'h1C);
      checks++; if (sv_pulses - sv0 !== 1) begin errors++; $display("FAIL make_sv_count: got %0d expected 1", sv_pulses - sv0); end
      checks++; if (last_code !== 8'h1C) begin errors++; $display("FAIL make_scan_code: got %h expected 1c", last_code); end
      checks++; if (kbd_at_sv !== 8'd0) begin errors++; $display("FAIL make_latency_n1: got %0d expected 0", kbd_at_sv); end
      checks++; if (kbd_after_sv !== 8'd65) begin errors++; $display("FAIL make_latency_n2: got %0d expected 65", kbd_after_sv); end
      checks++; if (keyboard !== 8'd65) begin errors++; $display("FAIL make_keyboard: got %0d expected 65", keyboard); end
   endtask

   task automatic test_break;
      send_byte(8'hF0); send_byte(8'h1C);
      checks++; if (keyboard !== 8'd0) begin errors++; $display("FAIL break_own: got %0d expected 0", keyboard); end
      send_byte(8'h1C);
      send_byte(8'hF0); send_byte(8'h32);
      checks++; if (keyboard !== 8'd65) begin errors++; $display("FAIL break_other: got %0d expected 65", keyboard); end
      send_byte(8'h1C);
      checks++; if (keyboard !== 8'd65) begin errors++; $display("FAIL typematic: got %0d expected 65", keyboard); end
      send_byte(8'h32);
      checks++; if (keyboard !== 8'd66) begin errors++; $display("FAIL make_replace: got %0d expected 66", keyboard); end
      send_byte(8'hF0); send_byte(8'h1C);
      checks++; if (keyboard !== 8'd66) begin errors++; $display("FAIL break_stale: got %0d expected 66", keyboard); end
      send_byte(8'hF0); send_byte(8'h32);
      checks++; if (keyboard !== 8'd0) begin errors++; $display("FAIL break_b: got %0d expected 0", keyboard); end
   endtask

   task automatic test_extended;
      logic [16:0] tbl [10];
      tbl = '{ {1'b0, 8'h5A, 8'd128}, {1'b0, 8'h66, 8'd129}, {1'b0, 8'h76, 8'd140},
               {1'b0, 8'h45, 8'd48},  {1'b0, 8'h46, 8'd57},  {1'b0, 8'h1A, 8'd90},
               {1'b0, 8'h4D, 8'd80},  {1'b1, 8'h74, 8'd132}, {1'b1, 8'h72, 8'd133},
               {1'b0, 8'h29, 8'd32} };
      send_byte(8'hE0); send_byte(8'h75);
      checks++; if (keyboard !== 8'd131) begin errors++; $display("FAIL ext_up_make: got %0d expected 131", keyboard); end
      send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
      checks++; if (keyboard !== 8'd0) begin errors++; $display("FAIL ext_up_break: got %0d expected 0", keyboard); end
      send_byte(8'h1C); send_byte(8'h75);
      checks++; if (keyboard !== 8'd65) begin errors++; $display("FAIL bare_75: got %0d expected 65", keyboard); end
      send_byte(8'hE0); send_byte(8'h6B);
      checks++; if (keyboard !== 8'd130) begin errors++; $display("FAIL ext_left: got %0d expected 130", keyboard); end
      for (int i = 0; i < 10; i++) begin
         if (tbl[i][16]) send_byte(8'hE0);
         send_byte(tbl[i][15:8]);
         checks++;
         if (keyboard !== tbl[i][7:0]) begin
            errors++;
            $display("FAIL table_%0d code %h: got %0d expected %0d", i, tbl[i][15:8], keyboard, tbl[i][7:0]);
         end
      end
   endtask

   task automatic test_parity;
      int sv0, fe0;
      send_byte(8'h32);
      sv0 = sv_pulses; fe0 = fe_pulses;
      send_bits(8'h5A, 1'b1, 1'b0, 11);
      checks++; if (fe_pulses - fe0 !== 1) begin errors++; $display("FAIL parity_err: got %0d expected 1", fe_pulses - fe0); end
      checks++; if (sv_pulses - sv0 !== 0) begin errors++; $display("FAIL parity_no_sv: got %0d expected 0", sv_pulses - sv0); end
      checks++; if (keyboard !== 8'd66) begin errors++; $display("FAIL parity_kbd: got %0d expected 66", keyboard); end
      fe0 = fe_pulses;
      send_bits(8'h1C, 1'b0, 1'b1, 11);
      checks++; if (fe_pulses - fe0 !== 1) begin errors++; $display("FAIL stop_err: got %0d expected 1", fe_pulses - fe0); end
      send_byte(8'hF0);
      send_bits(8'h32, 1'b1, 1'b0, 11);
      send_byte(8'h32);
      checks++; if (keyboard !== 8'd66) begin errors++; $display("FAIL err_clears_brk: got %0d expected 66", keyboard); end
   endtask

   task automatic test_timeout;
      int fe0, sv0, waited;
      sv0 = sv_pulses;
      send_bits(8'hA5, 1'b0, 1'b0, 5);
      fe0 = fe_pulses;
      waited = 0;
      while (waited < TIMEOUT + 100 && fe_pulses == fe0) begin
         @(negedge clk);
         waited++;
      end
      checks++; if (fe_pulses - fe0 !== 1) begin errors++; $display("FAIL timeout_err: got %0d expected 1 within %0d cycles", fe_pulses - fe0, TIMEOUT + 100); end
      checks++; if (waited < TIMEOUT - 100 || waited > TIMEOUT + 10) begin errors++; $display("FAIL timeout_delay: got %0d expected about %0d", waited, TIMEOUT - 25); end
      checks++; if (sv_pulses - sv0 !== 0) begin errors++; $display("FAIL timeout_no_sv: got %0d expected 0", sv_pulses - sv0); end
      send_byte(8'h29);
      checks++; if (keyboard !== 8'd32) begin errors++; $display("FAIL after_timeout: got %0d expected 32", keyboard); end
   endtask

   task automatic test_reset_midframe;
      int sv0, fe0;
      send_byte(8'h1C);
      send_bits(8'h3C, 1'b0, 1'b0, 4);
      @(negedge clk); rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      checks++; if (keyboard !== 8'd0) begin errors++; $display("FAIL midreset_kbd: got %0d expected 0", keyboard); end
      checks++; if (scan_code !== 8'd0) begin errors++; $display("FAIL midreset_code: got %h expected 00", scan_code); end
      checks++; if (scan_valid !== 1'b0 || frame_err !== 1'b0) begin errors++; $display("FAIL midreset_strobes: got %b%b expected 00", scan_valid, frame_err); end
      sv0 = sv_pulses; fe0 = fe_pulses;
      send_byte(8'h16);
      checks++; if (keyboard !== 8'd49) begin errors++; $display("FAIL midreset_next: got %0d expected 49", keyboard); end
      checks++; if (sv_pulses - sv0 !== 1 || fe_pulses - fe0 !== 0) begin errors++; $display("FAIL midreset_pulses: got sv=%0d fe=%0d expected sv=1 fe=0", sv_pulses - sv0, fe_pulses - fe0); end
   endtask

   task automatic test_glitch;
      int sv0, fe0;
      @(negedge clk);
      ps2_data = 1'b0;
      wait_cyc(5);
      ps2_clk = 1'b0;
      wait_cyc(2);
      ps2_clk = 1'b1;
      wait_cyc(5);
      ps2_data = 1'b1;
      wait_cyc(20);
      sv0 = sv_pulses; fe0 = fe_pulses;
      send_byte(8'h1C);
      checks++; if (keyboard !== 8'd65) begin errors++; $display("FAIL glitch_kbd: got %0d expected 65", keyboard); end
      checks++; if (last_code !== 8'h1C || sv_pulses - sv0 !== 1 || fe_pulses - fe0 !== 0) begin
         errors++; $display("FAIL glitch_frame: got code=%h sv=%0d fe=%0d expected 1c 1 0", last_code, sv_pulses - sv0, fe_pulses - fe0);
      end
   endtask

   task automatic test_strobes;
      checks++; if (both_cnt !== 0) begin errors++; $display("FAIL strobe_overlap: got %0d expected 0", both_cnt); end
      checks++; if (sv_long !== 0) begin errors++; $display("FAIL sv_width: got %0d extra cycles expected 0", sv_long); end
   endtask

   initial begin
      test_reset;
      test_make;
      test_break;
      test_extended;
      test_parity;
      test_timeout;
      test_reset_midframe;
      test_glitch;
      test_strobes;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
